// File: rtl/pipe_ctrl_if.sv
// Pipeline-controller bus: hazard/busy inputs, MEM-stage view, creg access and
// the stall/flush/redirect outputs. The pipeline side is master; pipe_ctrl is slave.
interface pipe_ctrl_if #(
  parameter int unsigned WORD_ADDR_W = 30
);
  logic                   if_busy;
  logic                   mem_busy;
  logic                   ld_hazard;
  logic                   irq;
  logic [WORD_ADDR_W-1:0] mem_pc;
  logic                   mem_en;
  logic [1:0]             mem_ctrl_op;
  logic [2:0]             mem_exp_code;
  logic [2:0]             creg_wr_addr;
  logic [31:0]            creg_wr_data;
  logic [2:0]             creg_rd_addr;
  logic [31:0]            creg_rd_data;
  logic                   if_stall, id_stall, ex_stall, mem_stall;
  logic                   if_flush, id_flush, ex_flush, mem_flush;
  logic                   pc_load;
  logic [WORD_ADDR_W-1:0] new_pc;
  logic                   int_en;

  modport master (
    output if_busy, mem_busy, ld_hazard, irq, mem_pc, mem_en, mem_ctrl_op,
           mem_exp_code, creg_wr_addr, creg_wr_data, creg_rd_addr,
    input  creg_rd_data, if_stall, id_stall, ex_stall, mem_stall,
           if_flush, id_flush, ex_flush, mem_flush, pc_load, new_pc, int_en
  );

  modport slave (
    input  if_busy, mem_busy, ld_hazard, irq, mem_pc, mem_en, mem_ctrl_op,
           mem_exp_code, creg_wr_addr, creg_wr_data, creg_rd_addr,
    output creg_rd_data, if_stall, id_stall, ex_stall, mem_stall,
           if_flush, id_flush, ex_flush, mem_flush, pc_load, new_pc, int_en
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: prioritised stall/flush/redirect decode, exception
// handling (EPC/cause/interrupt enable), handler-mode FSM and control registers.
module pipe_ctrl #(
  parameter int unsigned            WORD_ADDR_W = 30,
  parameter logic [WORD_ADDR_W-1:0] EXP_VECTOR  = WORD_ADDR_W'(4)
) (
  input  logic       clk,
  input  logic       reset,
  pipe_ctrl_if.slave bus
);
  typedef enum logic {NORMAL, HANDLER} mode_e;

  mode_e                  mode_q;
  logic                   int_en_q, pre_int_en_q;
  logic [WORD_ADDR_W-1:0] epc_q;
  logic [2:0]             cause_q;
  logic [31:0]            cycle_cnt_q, stall_cnt_q;

  logic ev_busy, ev_exc, ev_exrt, ev_wrcr, ev_haz;

  // Each event is masked by every higher-priority one so at most one is live.
  always_comb begin
    ev_busy = bus.if_busy | bus.mem_busy;
    ev_exc  = !ev_busy && bus.mem_en &&
              ((bus.mem_exp_code != 3'd0) || (bus.irq && int_en_q));
    ev_exrt = !ev_busy && !ev_exc && bus.mem_en && (bus.mem_ctrl_op == 2'd2);
    ev_wrcr = !ev_busy && !ev_exc && !ev_exrt && bus.mem_en &&
              (bus.mem_ctrl_op == 2'd1);
    ev_haz  = !ev_busy && !ev_exc && !ev_exrt && !ev_wrcr && bus.ld_hazard;
  end

  always_comb begin
    bus.if_stall  = 1'b0;
    bus.id_stall  = 1'b0;
    bus.ex_stall  = 1'b0;
    bus.mem_stall = 1'b0;
    bus.if_flush  = 1'b0;
    bus.id_flush  = 1'b0;
    bus.ex_flush  = 1'b0;
    bus.mem_flush = 1'b0;
    bus.pc_load   = 1'b0;
    bus.new_pc    = '0;
    if (!reset) begin
      if (ev_busy) begin
        bus.if_stall  = 1'b1;
        bus.id_stall  = 1'b1;
        bus.ex_stall  = 1'b1;
        bus.mem_stall = 1'b1;
      end else if (ev_exc || ev_exrt) begin
        bus.if_flush  = 1'b1;
        bus.id_flush  = 1'b1;
        bus.ex_flush  = 1'b1;
        bus.mem_flush = 1'b1;
        bus.pc_load   = 1'b1;
        bus.new_pc    = ev_exc ? EXP_VECTOR : epc_q;
      end else if (ev_haz) begin
        bus.if_stall = 1'b1;
        bus.id_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q       <= NORMAL;
      int_en_q     <= 1'b0;
      pre_int_en_q <= 1'b0;
      epc_q        <= '0;
      cause_q      <= '0;
      cycle_cnt_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (ev_busy || ev_haz)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (ev_exc) begin
        mode_q       <= HANDLER;
        epc_q        <= bus.mem_pc;
        cause_q      <= (bus.mem_exp_code != 3'd0) ? bus.mem_exp_code : 3'd7;
        pre_int_en_q <= int_en_q;
        int_en_q     <= 1'b0;
      end else if (ev_exrt) begin
        mode_q   <= NORMAL;
        int_en_q <= pre_int_en_q;
      end else if (ev_wrcr) begin
        // Later assignment overrides the counter increment above.
        case (bus.creg_wr_addr)
          3'd0:    int_en_q     <= bus.creg_wr_data[0];
          3'd1:    pre_int_en_q <= bus.creg_wr_data[0];
          3'd2:    epc_q        <= bus.creg_wr_data[WORD_ADDR_W+1:2];
          3'd3:    cause_q      <= bus.creg_wr_data[2:0];
          3'd4:    cycle_cnt_q  <= bus.creg_wr_data;
          3'd5:    stall_cnt_q  <= bus.creg_wr_data;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.creg_rd_data = '0;
    case (bus.creg_rd_addr)
      3'd0:    bus.creg_rd_data = {30'b0, mode_q == HANDLER, int_en_q};
      3'd1:    bus.creg_rd_data = {31'b0, pre_int_en_q};
      3'd2:    bus.creg_rd_data = 32'({epc_q, 2'b00});
      3'd3:    bus.creg_rd_data = {29'b0, cause_q};
      3'd4:    bus.creg_rd_data = cycle_cnt_q;
      3'd5:    bus.creg_rd_data = stall_cnt_q;
      default: bus.creg_rd_data = '0;
    endcase
  end

  assign bus.int_en = int_en_q;
endmodule
